tx_rate_sequencer: RTL and testbench
====================================

Name: tx_rate_sequencer

Overview:
- Single-clock controller that sequences the TX chain: mapper, 4x upsampler, SRRC filter and two half-band up-conversion stages.
- Generates the phase-aligned clock enables sym_clk_en, sam_clk_en and hb_clk_en from sys_clk.
- Runs a start/prime/flush sequence so the filters start from zero state and drain cleanly when transmission stops.
- Drives data_gate (zero-symbol insertion upstream of the mapper) and tx_valid (channel output meaningful).

Parameters:
HB_DIV, 2, sys_clk cycles per hb_clk_en pulse (>=1)
SAM_DIV, 2, hb_clk_en pulses per sam_clk_en pulse (>=1)
SYM_DIV, 4, sam_clk_en pulses per sym_clk_en pulse (>=1)
PRIME_SYMS, 6, symbols after start before tx_valid asserts (>=0)
FLUSH_SYMS, 6, zero symbols emitted after stop before idling (>=0)

Ports:
sys_clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  level request to transmit
hb_clk_en  output  1  half-band rate enable, one sys_clk wide
sam_clk_en  output  1  sample rate enable, one sys_clk wide
sym_clk_en  output  1  symbol rate enable, one sys_clk wide
sam_phase  output  $clog2(SYM_DIV) (min 1)  sample index within current symbol
data_gate  output  1  1 = pass tx_data, 0 = upstream forces zero symbol
tx_valid  output  1  chain output valid
busy  output  1  state != IDLE
state_out  output  2  00 IDLE, 01 RUN, 10 FLUSH

Behaviour:
- TOT = HB_DIV*SAM_DIV*SYM_DIV (16 at defaults).
- div_cnt counts 0..TOT-1 and wraps.
- All outputs are registered. Reset forces every output to 0, state to IDLE, and all counters to 0, asynchronously, including mid-symbol.
- IDLE: div_cnt held at 0; all enables 0; data_gate=0; tx_valid=0.
  - run=1 sampled at edge k moves the block to RUN with div_cnt=0.
  - Cycle after edge k: sym/sam/hb enables all 1, data_gate=1.
- Enable decode (RUN or FLUSH only):
  - hb_clk_en=1 iff div_cnt mod HB_DIV == 0.
  - sam_clk_en=1 iff div_cnt mod (HB_DIV*SAM_DIV) == 0.
  - sym_clk_en=1 iff div_cnt == 0.
  - sam_phase = div_cnt / (HB_DIV*SAM_DIV).
  - When all divisors are 1, every enable is held high.
- RUN:
  - sym_cnt increments at div_cnt==TOT-1 and saturates at PRIME_SYMS.
  - tx_valid rises in the cycle where sym_clk_en marks symbol index PRIME_SYMS (0-based). With PRIME_SYMS=0 it rises together with the first sym_clk_en.
  - run is checked only at div_cnt==TOT-1, so a symbol is never truncated.
  - If run=0 at that point: go to FLUSH (or to IDLE if FLUSH_SYMS=0), div_cnt wraps to 0, sym_cnt clears.
  - Pulses of run=0 that end before that point have no effect.
- FLUSH:
  - Enables continue with the same cadence and no phase slip.
  - data_gate=0; tx_valid holds its value.
  - sym_cnt counts completed symbols. At div_cnt==TOT-1 with sym_cnt==FLUSH_SYMS-1, go to IDLE; all outputs are 0 next cycle.
  - run is ignored in FLUSH. If run is still 1 on arrival in IDLE, RUN restarts one cycle later, with priming repeated and tx_valid 0.
- Simultaneous events: reset dominates everything. The run check and the wrap happen on the same edge.
- Counter widths: $clog2 of the maximum value + 1. No overflow is possible.

Test Plan:
- Reset, then run=1 at cycle 10: enables start cycle 12. sym_clk_en every 16 cycles, sam_clk_en every 4, hb_clk_en every 2, all coincident at symbol start. sam_phase cycles 0,1,2,3.
- Continuous run: tx_valid=0 for the first 6 symbols (96 cycles). It rises with the 7th sym_clk_en; data_gate=1 throughout.
- run drops at div_cnt=5: the current symbol completes and FLUSH starts at the next symbol boundary with data_gate=0. Exactly 6 more sym_clk_en pulses occur, then IDLE with all outputs 0 and busy=0.
- run toggles 1->0->1 within one symbol: no state change, no extra or missing enable.
- run held 1 through FLUSH: IDLE for exactly one cycle, then RUN again with tx_valid re-primed (0 for 6 symbols).
- reset asserted mid-FLUSH at div_cnt=7: all outputs 0 asynchronously. After release with run=1, the sequence restarts from div_cnt=0. Repeat with HB_DIV=SAM_DIV=SYM_DIV=1 and FLUSH_SYMS=0: enables held high continuously, and stopping goes straight from RUN to IDLE.

Source files
------------

// File: rtl/tx_rate_sequencer_if.sv
// Run request and rate-enable/status bundle of the TX rate sequencer.
// The slave modport is the sequencer; the master modport is whoever requests transmission.
interface tx_rate_sequencer_if #(
  parameter int SYM_DIV = 4
);
  localparam int PH_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  logic            run;
  logic            hb_clk_en;
  logic            sam_clk_en;
  logic            sym_clk_en;
  logic [PH_W-1:0] sam_phase;
  logic            data_gate;
  logic            tx_valid;
  logic            busy;
  logic [1:0]      state_out;

  modport master (
    output run,
    input  hb_clk_en, sam_clk_en, sym_clk_en, sam_phase,
    input  data_gate, tx_valid, busy, state_out
  );

  modport slave (
    input  run,
    output hb_clk_en, sam_clk_en, sym_clk_en, sam_phase,
    output data_gate, tx_valid, busy, state_out
  );
endinterface

// File: rtl/tx_rate_sequencer.sv
// TX chain sequencer: phase-aligned hb/sample/symbol enables from one divider,
// plus the start / prime / flush control of data_gate and tx_valid.
module tx_rate_sequencer #(
  parameter int HB_DIV     = 2,
  parameter int SAM_DIV    = 2,
  parameter int SYM_DIV    = 4,
  parameter int PRIME_SYMS = 6,
  parameter int FLUSH_SYMS = 6
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  tx_rate_sequencer_if.slave   bus
);
  localparam int TOT       = HB_DIV * SAM_DIV * SYM_DIV;
  localparam int SAM_TICKS = HB_DIV * SAM_DIV;
  localparam int DIV_W     = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int FL_MAX    = (FLUSH_SYMS > 0) ? FLUSH_SYMS - 1 : 0;
  localparam int SYM_MAX   = (PRIME_SYMS > FL_MAX) ? PRIME_SYMS : FL_MAX;
  localparam int SYM_W     = (SYM_MAX > 0) ? $clog2(SYM_MAX + 1) : 1;
  localparam int PH_W      = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [SYM_W-1:0]  r_sym_cnt;
  logic              r_hb_en;
  logic              r_sam_en;
  logic              r_sym_en;
  logic [PH_W-1:0]   r_sam_phase;
  logic              r_data_gate;
  logic              r_tx_valid;
  logic              r_busy;

  state_t            w_state_next;
  logic [DIV_W-1:0]  w_div_next;
  logic [SYM_W-1:0]  w_sym_next;
  logic              w_wrap;
  logic              w_active;
  logic              w_tx_valid_next;
  logic              w_hb_next;
  logic              w_sam_next;
  logic              w_sym_en_next;
  logic [PH_W-1:0]   w_phase_next;

  always_comb begin
    w_wrap       = (r_div_cnt == DIV_W'(TOT - 1));
    w_state_next = r_state;
    w_div_next   = '0;
    w_sym_next   = r_sym_cnt;

    case (r_state)
      S_IDLE: begin
        w_sym_next = '0;
        if (bus.run) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_div_next = w_wrap ? '0 : r_div_cnt + 1'b1;
        // run is only honoured on the last tick so a symbol is never cut short
        if (w_wrap) begin
          if (!bus.run) begin
            w_sym_next   = '0;
            w_state_next = (FLUSH_SYMS == 0) ? S_IDLE : S_FLUSH;
          end else if (int'(r_sym_cnt) < PRIME_SYMS) begin
            w_sym_next = r_sym_cnt + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        w_div_next = w_wrap ? '0 : r_div_cnt + 1'b1;
        if (w_wrap) begin
          if (int'(r_sym_cnt) == FLUSH_SYMS - 1) begin
            w_sym_next   = '0;
            w_state_next = S_IDLE;
          end else begin
            w_sym_next = r_sym_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_sym_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase

    case (w_state_next)
      S_RUN:   w_tx_valid_next = (int'(w_sym_next) >= PRIME_SYMS);
      S_FLUSH: w_tx_valid_next = r_tx_valid;
      default: w_tx_valid_next = 1'b0;
    endcase

    // outputs are decoded from the next-state values so they are registered yet aligned
    w_active      = (w_state_next != S_IDLE);
    w_hb_next     = w_active && ((int'(w_div_next) % HB_DIV) == 0);
    w_sam_next    = w_active && ((int'(w_div_next) % SAM_TICKS) == 0);
    w_sym_en_next = w_active && (w_div_next == '0);
    w_phase_next  = w_active ? PH_W'(int'(w_div_next) / SAM_TICKS) : '0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= '0;
      r_sym_cnt   <= '0;
      r_hb_en     <= 1'b0;
      r_sam_en    <= 1'b0;
      r_sym_en    <= 1'b0;
      r_sam_phase <= '0;
      r_data_gate <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_div_cnt   <= w_div_next;
      r_sym_cnt   <= w_sym_next;
      r_hb_en     <= w_hb_next;
      r_sam_en    <= w_sam_next;
      r_sym_en    <= w_sym_en_next;
      r_sam_phase <= w_phase_next;
      r_data_gate <= (w_state_next == S_RUN);
      r_tx_valid  <= w_tx_valid_next;
      r_busy      <= w_active;
    end
  end

  assign bus.hb_clk_en  = r_hb_en;
  assign bus.sam_clk_en = r_sam_en;
  assign bus.sym_clk_en = r_sym_en;
  assign bus.sam_phase  = r_sam_phase;
  assign bus.data_gate  = r_data_gate;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.busy       = r_busy;
  assign bus.state_out  = r_state;
endmodule

// File: tb/tb_tx_rate_sequencer.sv
// Bench for tx_rate_sequencer: default configuration plus an all-divisors-1 / no-flush
// configuration, checked every cycle against a segment-time reference model.
module tb_tx_rate_sequencer;
  localparam int A_HB = 2, A_SAM = 2, A_SYM = 4, A_PRIME = 6, A_FLUSH = 6;
  localparam int A_TOT = A_HB * A_SAM * A_SYM;
  localparam int B_HB = 1, B_SAM = 1, B_SYM = 1, B_PRIME = 6, B_FLUSH = 0;
  localparam int B_TOT = B_HB * B_SAM * B_SYM;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  tx_rate_sequencer_if #(.SYM_DIV(A_SYM)) bus_a ();
  tx_rate_sequencer_if #(.SYM_DIV(B_SYM)) bus_b ();

  tx_rate_sequencer #(.HB_DIV(A_HB), .SAM_DIV(A_SAM), .SYM_DIV(A_SYM),
                      .PRIME_SYMS(A_PRIME), .FLUSH_SYMS(A_FLUSH))
    dut_a (.sys_clk(sys_clk), .reset(reset), .bus(bus_a.slave));

  tx_rate_sequencer #(.HB_DIV(B_HB), .SAM_DIV(B_SAM), .SYM_DIV(B_SYM),
                      .PRIME_SYMS(B_PRIME), .FLUSH_SYMS(B_FLUSH))
    dut_b (.sys_clk(sys_clk), .reset(reset), .bus(bus_b.slave));

  // Model: mode 0 idle / 1 run / 2 flush, t = cycles since the segment's first active cycle.
  typedef struct {
    int mode;
    int t;
    bit hold;
  } model_t;

  typedef struct {
    logic       run;
    logic       hb;
    logic       sam;
    logic       sym;
    logic [1:0] ph;
    logic       gate;
    logic       valid;
    logic [1:0] st;
  } vec_t;

  int     nerr = 0;
  int     nchk = 0;
  model_t ma, mb;
  vec_t   vec[18];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic model_t mstep(model_t m, bit run, int tot, int prime, int flush);
    model_t r;
    r = m;
    case (m.mode)
      0: if (run) begin r.mode = 1; r.t = 0; end
      1: begin
        if (((m.t + 1) % tot == 0) && !run) begin
          r.hold = ((m.t / tot) >= prime);
          r.mode = (flush == 0) ? 0 : 2;
          r.t    = 0;
        end else begin
          r.t = m.t + 1;
        end
      end
      default: begin
        if (m.t + 1 == flush * tot) begin r.mode = 0; r.t = 0; end
        else r.t = m.t + 1;
      end
    endcase
    return r;
  endfunction

  // packed order: hb, sam, sym, phase[1:0], gate, valid, busy, state[1:0]
  function automatic logic [9:0] mexp(model_t m, int tot, int hbd, int samt, int prime);
    int   d;
    logic v;
    if (m.mode == 0) return 10'd0;
    d = m.t % tot;
    v = (m.mode == 1) ? ((m.t / tot) >= prime) : m.hold;
    return {(d % hbd) == 0, (d % samt) == 0, d == 0, 2'(d / samt),
            m.mode == 1, v, 1'b1, 2'(m.mode)};
  endfunction

  function automatic logic [9:0] pack_a();
    return {bus_a.hb_clk_en, bus_a.sam_clk_en, bus_a.sym_clk_en, bus_a.sam_phase,
            bus_a.data_gate, bus_a.tx_valid, bus_a.busy, bus_a.state_out};
  endfunction

  function automatic logic [9:0] pack_b();
    return {bus_b.hb_clk_en, bus_b.sam_clk_en, bus_b.sym_clk_en, 1'b0, bus_b.sam_phase,
            bus_b.data_gate, bus_b.tx_valid, bus_b.busy, bus_b.state_out};
  endfunction

  function automatic vec_t mk(int run, int hb, int sam, int sym, int ph, int gate, int valid, int st);
    vec_t v;
    v.run = run[0]; v.hb = hb[0]; v.sam = sam[0]; v.sym = sym[0];
    v.ph = ph[1:0]; v.gate = gate[0]; v.valid = valid[0]; v.st = st[1:0];
    return v;
  endfunction

  function automatic void model_reset();
    ma = '{mode: 0, t: 0, hold: 1'b0};
    mb = '{mode: 0, t: 0, hold: 1'b0};
  endfunction

  task automatic step();
    @(posedge sys_clk);
    if (reset) begin
      model_reset();
    end else begin
      ma = mstep(ma, bus_a.run, A_TOT, A_PRIME, A_FLUSH);
      mb = mstep(mb, bus_b.run, B_TOT, B_PRIME, B_FLUSH);
    end
    #1;
    check("model_a", 32'(pack_a()), 32'(mexp(ma, A_TOT, A_HB, A_HB * A_SAM, A_PRIME)));
    check("model_b", 32'(pack_b()), 32'(mexp(mb, B_TOT, B_HB, B_HB * B_SAM, B_PRIME)));
  endtask

  task automatic set_run(logic v);
    bus_a.run = v;
    bus_b.run = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] e;
    int n, nsym;

    // start-of-run table: one idle row, then div 0..15 and the next symbol start
    vec[0]  = mk(0, 0,0,0,0, 0,0,0);
    vec[1]  = mk(1, 1,1,1,0, 1,0,1);
    vec[2]  = mk(1, 0,0,0,0, 1,0,1);
    vec[3]  = mk(1, 1,0,0,0, 1,0,1);
    vec[4]  = mk(1, 0,0,0,0, 1,0,1);
    vec[5]  = mk(1, 1,1,0,1, 1,0,1);
    vec[6]  = mk(1, 0,0,0,1, 1,0,1);
    vec[7]  = mk(1, 1,0,0,1, 1,0,1);
    vec[8]  = mk(1, 0,0,0,1, 1,0,1);
    vec[9]  = mk(1, 1,1,0,2, 1,0,1);
    vec[10] = mk(1, 0,0,0,2, 1,0,1);
    vec[11] = mk(1, 1,0,0,2, 1,0,1);
    vec[12] = mk(1, 0,0,0,2, 1,0,1);
    vec[13] = mk(1, 1,1,0,3, 1,0,1);
    vec[14] = mk(1, 0,0,0,3, 1,0,1);
    vec[15] = mk(1, 1,0,0,3, 1,0,1);
    vec[16] = mk(1, 0,0,0,3, 1,0,1);
    vec[17] = mk(1, 1,1,1,0, 1,0,1);

    set_run(1'b0);
    model_reset();
    repeat (3) step();
    check("reset_state_a", 32'(pack_a()), 32'd0);
    check("reset_state_b", 32'(pack_b()), 32'd0);
    reset = 1'b0;
    $display("reset released at %0t", $time);

    for (int i = 0; i < 18; i++) begin
      set_run(vec[i].run);
      step();
      e = {vec[i].hb, vec[i].sam, vec[i].sym, vec[i].ph, vec[i].gate, vec[i].valid,
           vec[i].st != 2'd0, vec[i].st};
      check($sformatf("vec_%0d", i), 32'(pack_a()), 32'(e));
      $display("vec %0d run=%0b out=%b", i, vec[i].run, pack_a());
    end

    // priming: tx_valid rises with the 7th symbol enable, data_gate held meanwhile
    nsym = 2;
    n = 0;
    while (!bus_a.tx_valid && n < 300) begin
      step();
      if (bus_a.sym_clk_en) nsym++;
      check("prime_gate", 32'(bus_a.data_gate), 32'd1);
      n++;
    end
    check("prime_valid_reached", 32'(bus_a.tx_valid), 32'd1);
    check("prime_valid_sym_index", nsym, 7);
    check("prime_valid_on_sym", 32'(bus_a.sym_clk_en), 32'd1);
    $display("priming: tx_valid after %0d symbol enables", nsym);

    // short run=0 glitch inside a symbol
    n = 0;
    while (!(ma.mode == 1 && ma.t % A_TOT == 3) && n < 40) begin step(); n++; end
    check("glitch_reach", 32'(ma.t % A_TOT), 32'd3);
    set_run(1'b0); step(); step();
    set_run(1'b1); step();
    check("glitch_state", 32'(bus_a.state_out), 32'd1);
    check("glitch_gate", 32'(bus_a.data_gate), 32'd1);
    $display("glitch: state=%0d", bus_a.state_out);

    // stop at div 5: symbol completes, then exactly FLUSH_SYMS symbol enables
    n = 0;
    while (!(ma.mode == 1 && ma.t % A_TOT == 5) && n < 40) begin step(); n++; end
    check("stop_reach", 32'(ma.t % A_TOT), 32'd5);
    set_run(1'b0);
    step();
    check("b_stop_idle", 32'(bus_b.state_out), 32'd0);
    n = 0;
    while (bus_a.state_out != 2'd2 && n < 40) begin step(); n++; end
    check("flush_entry_state", 32'(bus_a.state_out), 32'd2);
    check("flush_entry_sym", 32'(bus_a.sym_clk_en), 32'd1);
    check("flush_entry_gate", 32'(bus_a.data_gate), 32'd0);
    check("flush_entry_cycles", n, 10);
    nsym = 1;
    n = 0;
    while (bus_a.state_out != 2'd0 && n < 200) begin
      step();
      if (bus_a.sym_clk_en) nsym++;
      n++;
    end
    check("flush_sym_count", nsym, A_FLUSH);
    check("flush_idle_outputs", 32'(pack_a()), 32'd0);
    $display("flush: %0d symbol enables then idle", nsym);

    // run held through FLUSH: one idle cycle, then re-primed run
    set_run(1'b1);
    n = 0;
    while (!bus_a.tx_valid && n < 300) begin step(); n++; end
    check("rerun_valid_reached", 32'(bus_a.tx_valid), 32'd1);
    set_run(1'b0);
    n = 0;
    while (bus_a.state_out != 2'd2 && n < 40) begin step(); n++; end
    check("rerun_flush_reached", 32'(bus_a.state_out), 32'd2);
    set_run(1'b1);
    n = 0;
    while (bus_a.state_out != 2'd0 && n < 200) begin step(); n++; end
    check("rerun_idle_reached", 32'(bus_a.state_out), 32'd0);
    step();
    check("rerun_one_idle_cycle", 32'(bus_a.state_out), 32'd1);
    check("rerun_sym_start", 32'(bus_a.sym_clk_en), 32'd1);
    n = 0;
    while (!bus_a.tx_valid && n < 300) begin n++; step(); end
    check("rerun_prime_cycles", n, A_PRIME * A_TOT);
    $display("restart: tx_valid re-primed after %0d cycles", n);

    // asynchronous reset mid-FLUSH at div 7
    set_run(1'b0);
    n = 0;
    while (!(ma.mode == 2 && ma.t % A_TOT == 7) && n < 100) begin step(); n++; end
    check("areset_reach", 32'(ma.mode * 100 + ma.t % A_TOT), 32'd207);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("areset_out_a", 32'(pack_a()), 32'd0);
    check("areset_out_b", 32'(pack_b()), 32'd0);
    set_run(1'b1);
    step();
    reset = 1'b0;
    step();
    check("areset_restart_state", 32'(bus_a.state_out), 32'd1);
    check("areset_restart_sym", 32'(bus_a.sym_clk_en), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("b_enables_high", 32'({bus_b.hb_clk_en, bus_b.sam_clk_en, bus_b.sym_clk_en}), 32'd7);
    end
    $display("async reset: restart state=%0d", bus_a.state_out);

    // randomized run levels with occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(29, 0) == 0) bus_a.run = ~bus_a.run;
      if ($urandom_range(19, 0) == 0) bus_b.run = ~bus_b.run;
      if ($urandom_range(999, 0) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rand_areset_a", 32'(pack_a()), 32'd0);
        check("rand_areset_b", 32'(pack_b()), 32'd0);
        reset = 1'b0;
      end
    end
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
